// File: rtl/line_tracker_ctrl.sv
// Line-following drive controller.
// The raw sensor bits are synchronised and debounced. The offset of the line
// is computed from the outermost detecting channels, and a small FSM turns
// that offset into a drive command. When the line is lost, the FSM steers in
// the last turn direction until a timeout expires.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | not enabled, drive stopped
// TRACK    | line visible, steer toward it (forward on centre or crossing)
// RECOVER  | line lost, repeat last turn while the lost timer runs
// HALT     | lost timer expired, stopped until the line reappears

module line_tracker_ctrl #(
    parameter int N_SENSORS    = 5,
    parameter int DEBOUNCE     = 4,
    parameter int LOST_TIMEOUT = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] track,
    output logic [1:0]           state,
    output logic signed [4:0]    error,
    output logic                 line_valid,
    output logic                 lost
);

    localparam logic [N_SENSORS-1:0] NO_LINE  = (ACTIVE_LOW != 0) ? {N_SENSORS{1'b1}}
                                                                   : {N_SENSORS{1'b0}};
    localparam logic [7:0]           DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [19:0]          TMR_LIM  = 20'(LOST_TIMEOUT);
    localparam logic [19:0]          TMR_LAST = 20'(LOST_TIMEOUT - 1);

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_RIGHT = 2'b01;
    localparam logic [1:0] CMD_LEFT  = 2'b10;
    localparam logic [1:0] CMD_FWD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_RECOVER = 2'd2,
        S_HALT    = 2'd3
    } fsm_t;

    logic [N_SENSORS-1:0] sync1;
    logic [N_SENSORS-1:0] sync2;
    logic [N_SENSORS-1:0] filt;
    logic [7:0]           db_cnt [N_SENSORS];
    logic [N_SENSORS-1:0] detect;
    logic                 any_c;
    logic                 all_c;
    logic signed [4:0]    err_c;
    logic [1:0]           trk_cmd;
    logic                 turn_c;
    int                   lo_idx;
    int                   hi_idx;
    fsm_t                 fsm;
    logic [1:0]           last_dir;
    logic [19:0]          timer;

    // Two-flop synchroniser, preset to the no-line level so reset looks like "no line".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= NO_LINE;
            sync2 <= NO_LINE;
        end else begin
            sync1 <= track;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: a channel flips only after DEBOUNCE consecutive mismatching edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= NO_LINE;
            for (int i = 0; i < N_SENSORS; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= 8'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Line offset from the outermost detecting channels, and the steering command it implies.
    always_comb begin
        detect = (ACTIVE_LOW != 0) ? ~filt : filt;
        any_c  = 1'b0;
        lo_idx = 0;
        hi_idx = 0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (detect[i]) begin
                if (!any_c) begin
                    lo_idx = i;
                end
                hi_idx = i;
                any_c  = 1'b1;
            end
        end
        all_c = &detect;
        err_c = any_c ? 5'(lo_idx + hi_idx - (N_SENSORS - 1)) : 5'sd0;
        if (all_c || err_c == 5'sd0) begin
            trk_cmd = CMD_FWD;
        end else if (err_c < 5'sd0) begin
            trk_cmd = CMD_LEFT;
        end else begin
            trk_cmd = CMD_RIGHT;
        end
        turn_c = (trk_cmd != CMD_FWD);
    end

    // Sequencing FSM with registered outputs. The decision uses the filtered bits
    // directly, so a command appears on the same edge as the matching error/line_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= S_IDLE;
            state      <= CMD_STOP;
            error      <= 5'sd0;
            line_valid <= 1'b0;
            lost       <= 1'b0;
            last_dir   <= CMD_FWD;
            timer      <= 20'd0;
        end else begin
            error      <= err_c;
            line_valid <= any_c;
            if (!enable) begin
                fsm   <= S_IDLE;
                state <= CMD_STOP;
                lost  <= 1'b0;
            end else begin
                case (fsm)
                    S_IDLE: begin
                        if (any_c) begin
                            fsm   <= S_TRACK;
                            state <= trk_cmd;
                            lost  <= 1'b0;
                            if (turn_c) last_dir <= trk_cmd;
                        end else begin
                            fsm   <= S_RECOVER;
                            timer <= 20'd0;
                            state <= last_dir;
                            lost  <= 1'b1;
                        end
                    end
                    S_TRACK: begin
                        if (any_c) begin
                            state <= trk_cmd;
                            lost  <= 1'b0;
                            if (turn_c) last_dir <= trk_cmd;
                        end else begin
                            fsm   <= S_RECOVER;
                            timer <= 20'd0;
                            state <= last_dir;
                            lost  <= 1'b1;
                        end
                    end
                    S_RECOVER: begin
                        if (any_c) begin
                            fsm   <= S_TRACK;
                            state <= trk_cmd;
                            lost  <= 1'b0;
                            if (turn_c) last_dir <= trk_cmd;
                        end else if (timer >= TMR_LAST) begin
                            fsm   <= S_HALT;
                            timer <= TMR_LIM;
                            state <= CMD_STOP;
                            lost  <= 1'b1;
                        end else begin
                            timer <= timer + 20'd1;
                            state <= last_dir;
                            lost  <= 1'b1;
                        end
                    end
                    default: begin
                        if (any_c) begin
                            fsm   <= S_TRACK;
                            state <= trk_cmd;
                            lost  <= 1'b0;
                            if (turn_c) last_dir <= trk_cmd;
                        end else begin
                            state <= CMD_STOP;
                            lost  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/line_tracker_ctrl.md
LINE_TRACKER_CTRL -- requirements
Module: line_tracker_ctrl

Interface
REQ-001 SHALL provide parameter N_SENSORS, default 5, number of tracker channels, odd, 3..15, index 0 = leftmost.
REQ-002 SHALL provide parameter DEBOUNCE, default 4, consecutive-cycle stability count per channel, 1..255.
REQ-003 SHALL provide parameter LOST_TIMEOUT, default 1000, RECOVER-state cycle budget, 1..2^20-1.
REQ-004 SHALL provide parameter ACTIVE_LOW, default 1; 1 = line detected when sensor reads 0.
REQ-005 SHALL have ports clk  input  1  system clock.
REQ-006 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have enable  input  1  run request; 0 forces IDLE.
REQ-008 SHALL have track  input  N_SENSORS  raw asynchronous sensor levels.
REQ-009 SHALL have state  output  2  drive command: 00 stop, 01 right, 10 left, 11 forward.
REQ-010 SHALL have error  output  5  signed two's-complement line offset.
REQ-011 SHALL have line_valid  output  1  at least one filtered channel detects line.
REQ-012 SHALL have lost  output  1  FSM in RECOVER or HALT.

Function
REQ-013 SHALL pass each track bit through a 2-flop synchroniser.
REQ-014 SHALL update a filtered channel bit only once its synchronised value has differed from it for DEBOUNCE consecutive edges; any mismatch break restarts that channel's counter.
REQ-015 SHALL convert filtered bits to detect bits: detect = ~filtered if ACTIVE_LOW, else filtered.
REQ-016 SHALL compute lo/hi = lowest/highest detecting index; error = lo + hi - (N_SENSORS-1); error = 0 when no channel detects.
REQ-017 SHALL register all outputs; a stable input change is visible on outputs at edge 3+DEBOUNCE after the first edge that samples it.
REQ-018 SHALL implement FSM states IDLE, TRACK, RECOVER, HALT.
REQ-019 IDLE: state=00; enable=1 -> TRACK if line_valid, else RECOVER.
REQ-020 TRACK: error<0 -> 10 left; error>0 -> 01 right; error=0 -> 11 forward; record last nonzero turn (left/right) as last_dir.
REQ-021 TRACK: all channels detecting (crossing) -> 11 forward, last_dir unchanged.
REQ-022 TRACK: line_valid falls -> RECOVER, lost timer cleared.
REQ-023 RECOVER: state = last_dir command (forward 11 if no turn recorded since reset); timer increments each cycle.
REQ-024 RECOVER: line_valid=1 -> TRACK next edge; timer reaching LOST_TIMEOUT with no line -> HALT.
REQ-025 HALT: state=00, lost=1; leave only to TRACK when line_valid=1 for one cycle, or to IDLE on enable=0.
REQ-026 enable=0 in any state -> IDLE next edge, state=00 that same edge; takes priority over all other transitions.
REQ-027 Timer SHALL saturate at LOST_TIMEOUT, never wrap.

Reset
REQ-028 Asynchronous reset SHALL force: FSM IDLE, state=00, error=0, line_valid=0, lost=0, last_dir=none, timer=0.
REQ-029 Reset SHALL preset synchronisers and filtered bits to the no-line level (all 1 if ACTIVE_LOW), and clear debounce counters.
REQ-030 Reset mid-operation SHALL take effect immediately, without waiting for clk; first post-reset decision requires full REQ-017 latency.

Verification (N_SENSORS=5, DEBOUNCE=4, LOST_TIMEOUT=16, ACTIVE_LOW=1)
REQ-031 enable=1, track=11011 stable -> after 7 edges: state=11, error=0, line_valid=1, lost=0.
REQ-032 track=10111 stable (line at index 1) -> error=-2, state=10; track=11110 -> error=+4, state=01.
REQ-033 Glitch: track 11011 -> 01011 for 3 cycles -> back; filtered unchanged, state stays 11, error stays 0.
REQ-034 From state=10 tracking, track=11111 -> RECOVER, state=10, lost=1; 16 cycles no line -> HALT, state=00; then track=11011 -> TRACK, state=11, lost=0.
REQ-035 track=00000 (crossing) after a right turn -> state=11, error=0; then all-lost -> RECOVER with state=01.
REQ-036 Reset asserted between edges while state=01 -> outputs 00/0/0/0 immediately; enable=0 during TRACK -> state=00 next edge.
